// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing the UART TX register port between two byte requesters
// Brings the UART out of reset, then drains two per-requester FIFOs via poll-then-write transactions.
module uart_tx_arbiter #(
  parameter logic [31:0] BAUD_DIV = 32'h1B8,
  parameter int          DEPTH    = 4,
  parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  input  logic [7:0]  req0_data_i,
  output logic        req0_ready_o,
  input  logic        req1_valid_i,
  input  logic [7:0]  req1_data_i,
  output logic        req1_ready_o,
  output logic        uart_req_o,
  output logic        uart_we_o,
  output logic [31:0] uart_addr_o,
  output logic [31:0] uart_wdata_o,
  input  logic        uart_ready_i,
  input  logic [31:0] uart_rdata_i,
  output logic        busy_o,
  output logic        grant_o,
  output logic        err_o
);

  localparam int          PW          = $clog2(DEPTH);
  localparam logic [PW:0] FULL        = (PW + 1)'(DEPTH);
  localparam logic [31:0] ADDR_CTRL   = 32'h0000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_0004;
  localparam logic [31:0] ADDR_BAUD   = 32'h0000_0008;
  localparam logic [31:0] ADDR_DATA   = 32'h0000_000C;
  localparam logic [31:0] CTRL_EN     = 32'h0000_0003;

  typedef enum logic [2:0] {
    INIT_CTRL,
    INIT_BAUD,
    IDLE,
    POLL,
    WRITE
  } state_e;

  state_e        state_q;
  logic          sel_q;
  logic          last_q;
  logic [15:0]   tmo_q;

  logic [7:0]    mem_q  [2][DEPTH];
  logic [PW-1:0] wptr_q [2];
  logic [PW-1:0] rptr_q [2];
  logic [PW:0]   cnt_q  [2];

  logic [7:0]    din    [2];
  logic [7:0]    head   [2];
  logic [1:0]    rdy;
  logic [1:0]    ne;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic          pick;
  logic          timeout_hit;
  logic          write_done;
  logic          unused_rdata;

  // Only the TX-busy bit of the status register matters here.
  assign unused_rdata = ^uart_rdata_i[31:1];

  assign din[0] = req0_data_i;
  assign din[1] = req1_data_i;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rdy[i]  = (cnt_q[i] != FULL);
      ne[i]   = (cnt_q[i] != '0);
      head[i] = mem_q[i][rptr_q[i]];
    end
  end

  assign push[0] = req0_valid_i & rdy[0];
  assign push[1] = req1_valid_i & rdy[1];

  assign timeout_hit = (state_q == WRITE) && !uart_ready_i && (tmo_q == TIMEOUT - 16'd1);
  assign write_done  = (state_q == WRITE) && (uart_ready_i || timeout_hit);
  assign pop[0]      = write_done && !sel_q;
  assign pop[1]      = write_done && sel_q;

  // Under contention the requester not served last wins; otherwise the only non-empty one.
  assign pick = (ne[0] && ne[1]) ? ~last_q : ne[1];

  assign req0_ready_o = rdy[0];
  assign req1_ready_o = rdy[1];
  assign busy_o       = (state_q != IDLE) || (|ne);
  assign grant_o      = sel_q;
  assign err_o        = timeout_hit;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= din[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + PW'(1);
        if (push[i] && !pop[i]) begin
          cnt_q[i] <= cnt_q[i] + (PW + 1)'(1);
        end else if (!push[i] && pop[i]) begin
          cnt_q[i] <= cnt_q[i] - (PW + 1)'(1);
        end
      end
    end
  end

  // Bus outputs are loaded on each transition so they hold steady until the UART accepts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= INIT_CTRL;
      sel_q        <= 1'b0;
      last_q       <= 1'b1;
      tmo_q        <= '0;
      uart_req_o   <= 1'b1;
      uart_we_o    <= 1'b1;
      uart_addr_o  <= ADDR_CTRL;
      uart_wdata_o <= CTRL_EN;
    end else begin
      case (state_q)
        INIT_CTRL: begin
          if (uart_ready_i) begin
            state_q      <= INIT_BAUD;
            uart_addr_o  <= ADDR_BAUD;
            uart_wdata_o <= BAUD_DIV;
          end
        end
        INIT_BAUD: begin
          if (uart_ready_i) begin
            state_q      <= IDLE;
            uart_req_o   <= 1'b0;
            uart_we_o    <= 1'b0;
            uart_addr_o  <= '0;
            uart_wdata_o <= '0;
          end
        end
        IDLE: begin
          if (|ne) begin
            state_q     <= POLL;
            sel_q       <= pick;
            uart_req_o  <= 1'b1;
            uart_we_o   <= 1'b0;
            uart_addr_o <= ADDR_STATUS;
          end
        end
        POLL: begin
          if (uart_ready_i && !uart_rdata_i[0]) begin
            state_q      <= WRITE;
            tmo_q        <= '0;
            uart_we_o    <= 1'b1;
            uart_addr_o  <= ADDR_DATA;
            uart_wdata_o <= {24'h0, head[sel_q]};
          end
        end
        WRITE: begin
          if (write_done) begin
            state_q      <= IDLE;
            uart_req_o   <= 1'b0;
            uart_we_o    <= 1'b0;
            uart_addr_o  <= '0;
            uart_wdata_o <= '0;
            if (uart_ready_i) last_q <= sel_q;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        default: begin
          state_q <= INIT_CTRL;
        end
      endcase
    end
  end

endmodule
